// File: rtl/seg_pkg.sv
// Shared types and constants for the 7-segment scan path.
// Digit words are packed so a whole BCD value moves as one 16-bit bus.
package seg_pkg;
    localparam int          NDIG        = 4;
    localparam logic [15:0] MAX_DISPLAY = 16'd9999;
    localparam logic [3:0]  CODE_LAMP   = 4'd10;
    localparam logic [3:0]  CODE_DASH   = 4'd11;

    typedef logic [3:0] bcd_digit_t;
    typedef bcd_digit_t [NDIG-1:0] bcd_word_t;

    // Double-dabble correction: any nibble >= 5 gets +3 before the shift.
    function automatic bcd_word_t dabble_adjust(input bcd_word_t w);
        bcd_word_t r;
        for (int i = 0; i < NDIG; i++) begin
            r[i] = (w[i] >= 4'd5) ? w[i] + 4'd3 : w[i];
        end
        return r;
    endfunction
endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 16-bit binary to 4-digit BCD converter, one bit per clock.
// done is high in the final iteration cycle; bcd then holds the finished word.
module bin2bcd_seq
    import seg_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] bin,
    output logic        busy,
    output logic        done,
    output bcd_word_t   bcd
);
    logic [15:0] sh;
    bcd_word_t   acc;
    logic [3:0]  iter;
    logic [31:0] shifted;

    // The fifth decade falls off the top here; overflow is flagged elsewhere.
    always_comb begin
        shifted = {dabble_adjust(acc), sh} << 1;
    end

    assign bcd  = shifted[31:16];
    assign done = busy && (iter == 4'd15);

    always_ff @(posedge clk) begin
        if (reset) begin
            busy <= 1'b0;
            iter <= '0;
            sh   <= '0;
            acc  <= '0;
        end else if (start && !busy) begin
            busy <= 1'b1;
            iter <= '0;
            sh   <= bin;
            acc  <= '0;
        end else if (busy) begin
            acc  <= shifted[31:16];
            sh   <= shifted[15:0];
            iter <= iter + 4'd1;
            if (iter == 4'd15) begin
                busy <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/seg_scan_driver.sv
// Latches a 16-bit value, converts it to BCD and scans four common-anode digits.
// Display and overflow flag update together when conversion completes.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int DWELL_CYCLES = 12500
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] value,
    input  logic        load,
    input  logic        blank_lz,
    input  logic        lamp_test,
    output logic [3:0]  num,
    output logic [3:0]  digit_en,
    output logic        busy
);
    localparam int DW_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;

    logic            start;
    logic            conv_done;
    bcd_word_t       conv_bcd;
    bcd_word_t       disp;
    logic            ovf;
    logic            pend_ovf;
    logic [DW_W-1:0] dwell_cnt;
    logic [1:0]      scan_idx;
    logic [NDIG-1:0] zero_from;
    logic            blank;
    logic [3:0]      num_next;
    logic [3:0]      en_next;

    assign start = load && !busy;

    bin2bcd_seq u_conv (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .bin   (value),
        .busy  (busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    // zero_from[i]: digits i..3 are all zero.
    always_comb begin
        zero_from = '0;
        for (int i = 0; i < NDIG; i++) begin
            zero_from[i] = 1'b1;
            for (int j = i; j < NDIG; j++) begin
                if (disp[j] != 4'd0) zero_from[i] = 1'b0;
            end
        end
        blank = blank_lz && !lamp_test && !ovf && (scan_idx != 2'd0) && zero_from[scan_idx];

        if (lamp_test)      num_next = CODE_LAMP;
        else if (ovf)       num_next = CODE_DASH;
        else                num_next = disp[scan_idx];

        // Guard cycle at slot start keeps the previous digit from ghosting.
        if ((dwell_cnt == '0) || blank) en_next = 4'b1111;
        else                            en_next = ~(4'b0001 << scan_idx);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            disp      <= '0;
            ovf       <= 1'b0;
            pend_ovf  <= 1'b0;
            dwell_cnt <= '0;
            scan_idx  <= '0;
            num       <= 4'd0;
            digit_en  <= 4'b1111;
        end else begin
            if (start) begin
                pend_ovf <= (value > MAX_DISPLAY);
            end
            if (conv_done) begin
                disp <= conv_bcd;
                ovf  <= pend_ovf;
            end
            if (dwell_cnt == DW_W'(DWELL_CYCLES - 1)) begin
                dwell_cnt <= '0;
                scan_idx  <= scan_idx + 2'd1;
            end else begin
                dwell_cnt <= dwell_cnt + 1'b1;
            end
            num      <= num_next;
            digit_en <= en_next;
        end
    end
endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with DWELL_CYCLES=4 (one frame = 16 clocks).
module tb_seg_scan_driver;
    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] value;
    logic        load;
    logic        blank_lz;
    logic        lamp_test;
    logic [3:0]  num;
    logic [3:0]  digit_en;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int t = 0;

    logic [3:0] obs_num [16];
    logic [3:0] obs_en  [16];
    int         obs_s   [16];
    logic [3:0] exp_n   [4];

    seg_scan_driver #(.DWELL_CYCLES(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .value     (value),
        .load      (load),
        .blank_lz  (blank_lz),
        .lamp_test (lamp_test),
        .num       (num),
        .digit_en  (digit_en),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Non-reset edges since the last reset; output after edge t shows state t-1.
    always @(posedge clk) begin
        if (reset) t <= 0;
        else       t <= t + 1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at time %0t", $time);
        $fatal(1, "watchdog");
    end

    function automatic logic [3:0] exp_en(input int s, input logic [3:0] on);
        int i;
        i = (s / 4) % 4;
        if ((s % 4 == 0) || !on[i]) return 4'b1111;
        return ~(4'b0001 << i);
    endfunction

    task automatic capture_frame();
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            obs_num[k] = num;
            obs_en[k]  = digit_en;
            obs_s[k]   = t - 1;
        end
    endtask

    task automatic do_load(input logic [15:0] v);
        value = v;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; load = 1'b0; value = '0; blank_lz = 1'b1; lamp_test = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || digit_en !== 4'b1111 || num !== 4'd0) begin
                errors++;
                $display("FAIL reset_state cyc=%0d got busy=%b en=%b num=%0d want 0/1111/0", k, busy, digit_en, num);
            end
        end
        reset = 1'b0;
        exp_n = '{4'd0, 4'd0, 4'd0, 4'd0};
        capture_frame();
        for (int k = 0; k < 16; k++) begin
            checks += 2;
            if (obs_num[k] !== exp_n[(obs_s[k] / 4) % 4]) begin
                errors++;
                $display("FAIL reset_frame_num k=%0d got %0d want %0d", k, obs_num[k], exp_n[(obs_s[k] / 4) % 4]);
            end
            if (obs_en[k] !== exp_en(obs_s[k], 4'b0001)) begin
                errors++;
                $display("FAIL reset_frame_en k=%0d got %b want %b", k, obs_en[k], exp_en(obs_s[k], 4'b0001));
            end
        end
    endtask

    task automatic test_convert();
        int n, i;
        blank_lz = 1'b0;
        do_load(16'd1234);
        wait_idle(n);
        checks++;
        if (n != 16) begin
            errors++;
            $display("FAIL busy_len_1234 got %0d want 16", n);
        end
        // Edge 17 commits; its output still reflects the old (all-zero) display.
        checks++;
        if (num !== 4'd0) begin
            errors++;
            $display("FAIL pre_commit_num got %0d want 0", num);
        end
        exp_n = '{4'd4, 4'd3, 4'd2, 4'd1};
        @(negedge clk);
        i = ((t - 1) / 4) % 4;
        checks++;
        if (num !== exp_n[i]) begin
            errors++;
            $display("FAIL post_commit_num got %0d want %0d", num, exp_n[i]);
        end
        capture_frame();
        for (int k = 0; k < 16; k++) begin
            checks += 2;
            if (obs_num[k] !== exp_n[(obs_s[k] / 4) % 4]) begin
                errors++;
                $display("FAIL frame_1234_num k=%0d got %0d want %0d", k, obs_num[k], exp_n[(obs_s[k] / 4) % 4]);
            end
            if (obs_en[k] !== exp_en(obs_s[k], 4'b1111)) begin
                errors++;
                $display("FAIL frame_1234_en k=%0d got %b want %b", k, obs_en[k], exp_en(obs_s[k], 4'b1111));
            end
        end
    endtask

    task automatic test_overflow();
        int n;
        logic [15:0] vals [3];
        logic [3:0]  codes [3];
        vals  = '{16'd10000, 16'd65535, 16'd9999};
        codes = '{4'd11, 4'd11, 4'd9};
        blank_lz = 1'b1;
        for (int v = 0; v < 3; v++) begin
            do_load(vals[v]);
            wait_idle(n);
            checks++;
            if (n != 16) begin
                errors++;
                $display("FAIL busy_len_ovf v=%0d got %0d want 16", vals[v], n);
            end
            capture_frame();
            for (int k = 0; k < 16; k++) begin
                checks += 2;
                if (obs_num[k] !== codes[v]) begin
                    errors++;
                    $display("FAIL ovf_num v=%0d k=%0d got %0d want %0d", vals[v], k, obs_num[k], codes[v]);
                end
                if (obs_en[k] !== exp_en(obs_s[k], 4'b1111)) begin
                    errors++;
                    $display("FAIL ovf_en v=%0d k=%0d got %b want %b", vals[v], k, obs_en[k], exp_en(obs_s[k], 4'b1111));
                end
            end
        end
    endtask

    task automatic test_blanking();
        int n;
        blank_lz = 1'b1;
        do_load(16'd42);
        wait_idle(n);
        exp_n = '{4'd2, 4'd4, 4'd0, 4'd0};
        capture_frame();
        for (int k = 0; k < 16; k++) begin
            checks += 2;
            if (obs_num[k] !== exp_n[(obs_s[k] / 4) % 4]) begin
                errors++;
                $display("FAIL blank_num k=%0d got %0d want %0d", k, obs_num[k], exp_n[(obs_s[k] / 4) % 4]);
            end
            if (obs_en[k] !== exp_en(obs_s[k], 4'b0011)) begin
                errors++;
                $display("FAIL blank_en k=%0d got %b want %b", k, obs_en[k], exp_en(obs_s[k], 4'b0011));
            end
        end
        blank_lz = 1'b0;
        capture_frame();
        for (int k = 0; k < 16; k++) begin
            checks += 2;
            if (obs_num[k] !== exp_n[(obs_s[k] / 4) % 4]) begin
                errors++;
                $display("FAIL unblank_num k=%0d got %0d want %0d", k, obs_num[k], exp_n[(obs_s[k] / 4) % 4]);
            end
            if (obs_en[k] !== exp_en(obs_s[k], 4'b1111)) begin
                errors++;
                $display("FAIL unblank_en k=%0d got %b want %b", k, obs_en[k], exp_en(obs_s[k], 4'b1111));
            end
        end
    endtask

    task automatic test_lamp();
        int n;
        blank_lz = 1'b1;
        do_load(16'd7);
        wait_idle(n);
        lamp_test = 1'b1;
        capture_frame();
        for (int k = 0; k < 16; k++) begin
            checks += 2;
            if (obs_num[k] !== 4'd10) begin
                errors++;
                $display("FAIL lamp_num k=%0d got %0d want 10", k, obs_num[k]);
            end
            if (obs_en[k] !== exp_en(obs_s[k], 4'b1111)) begin
                errors++;
                $display("FAIL lamp_en k=%0d got %b want %b", k, obs_en[k], exp_en(obs_s[k], 4'b1111));
            end
        end
        lamp_test = 1'b0;
        exp_n = '{4'd7, 4'd0, 4'd0, 4'd0};
        capture_frame();
        for (int k = 0; k < 16; k++) begin
            checks += 2;
            if (obs_num[k] !== exp_n[(obs_s[k] / 4) % 4]) begin
                errors++;
                $display("FAIL lamp_off_num k=%0d got %0d want %0d", k, obs_num[k], exp_n[(obs_s[k] / 4) % 4]);
            end
            if (obs_en[k] !== exp_en(obs_s[k], 4'b0001)) begin
                errors++;
                $display("FAIL lamp_off_en k=%0d got %b want %b", k, obs_en[k], exp_en(obs_s[k], 4'b0001));
            end
        end
    endtask

    task automatic test_back_to_back();
        int n;
        blank_lz = 1'b0;
        do_load(16'd1234);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            if (n == 5) begin
                value = 16'd5678;
                load  = 1'b1;
            end else begin
                load  = 1'b0;
            end
            @(negedge clk);
        end
        load = 1'b0;
        checks++;
        if (n != 16) begin
            errors++;
            $display("FAIL busy_len_ignored_load got %0d want 16", n);
        end
        exp_n = '{4'd4, 4'd3, 4'd2, 4'd1};
        capture_frame();
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (obs_num[k] !== exp_n[(obs_s[k] / 4) % 4]) begin
                errors++;
                $display("FAIL ignored_load_num k=%0d got %0d want %0d", k, obs_num[k], exp_n[(obs_s[k] / 4) % 4]);
            end
        end

        do_load(16'd5678);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            if (n == 8) break;
            @(negedge clk);
        end
        checks++;
        if (n != 8) begin
            errors++;
            $display("FAIL abort_reach_cycle8 got %0d want 8", n);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || digit_en !== 4'b1111 || num !== 4'd0) begin
            errors++;
            $display("FAIL abort_reset got busy=%b en=%b num=%0d want 0/1111/0", busy, digit_en, num);
        end
        reset = 1'b0;
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b0) begin
                errors++;
                $display("FAIL abort_busy_stays_low k=%0d got %b want 0", k, busy);
            end
        end
        exp_n = '{4'd0, 4'd0, 4'd0, 4'd0};
        capture_frame();
        for (int k = 0; k < 16; k++) begin
            checks += 2;
            if (obs_num[k] !== exp_n[(obs_s[k] / 4) % 4]) begin
                errors++;
                $display("FAIL abort_num k=%0d got %0d want 0", k, obs_num[k]);
            end
            if (obs_en[k] !== exp_en(obs_s[k], 4'b1111)) begin
                errors++;
                $display("FAIL abort_en k=%0d got %b want %b", k, obs_en[k], exp_en(obs_s[k], 4'b1111));
            end
        end
    endtask

    initial begin
        test_reset();
        test_convert();
        test_overflow();
        test_blanking();
        test_lamp();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
